axonerve_kvs_axis_unpacker: RTL

- Reader/consumer for the kernel's wide AXI4-Stream data path.
- Accepts C_AXIS_TDATA_WIDTH-bit beats, such as the per-lane adder output, and serialises them into C_OUT_WIDTH-bit words, one per transfer, lowest lane first.
- Lanes whose tkeep bytes are all zero are skipped. Packet boundaries (tlast) are preserved.
- Sits between the wide stream processing stage and the narrow KVS key/value ingest logic.

---
 rtl/axonerve_kvs_axis_unpacker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axonerve_kvs_axis_unpacker.sv
// Wide-to-narrow AXI4-Stream unpacker: splits each input beat into C_OUT_WIDTH
// words, lowest lane first, skipping lanes with no enabled bytes.
module axonerve_kvs_axis_unpacker #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_OUT_WIDTH        = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_OUT_WIDTH-1:0]          m_axis_tdata,
  output logic [C_OUT_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int LP_NUM_LANES = C_AXIS_TDATA_WIDTH / C_OUT_WIDTH;
  localparam int LP_KEEP_W    = C_OUT_WIDTH / 8;
  localparam int LP_SEL_W     = (LP_NUM_LANES > 1) ? $clog2(LP_NUM_LANES) : 1;

  logic [C_AXIS_TDATA_WIDTH-1:0]   buf_data_reg;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] buf_keep_reg;
  logic                            buf_last_reg;
  logic [LP_NUM_LANES-1:0]         buf_mask_reg;
  logic                            buf_null_reg;
  logic                            run_reg;

  logic                            out_valid_reg;
  logic [C_OUT_WIDTH-1:0]          out_data_reg;
  logic [LP_KEEP_W-1:0]            out_keep_reg;
  logic                            out_last_reg;

  logic [LP_NUM_LANES-1:0]         in_lane_mask;
  logic [C_OUT_WIDTH-1:0]          buf_lane      [LP_NUM_LANES];
  logic [LP_KEEP_W-1:0]            buf_lane_keep [LP_NUM_LANES];
  logic [LP_SEL_W-1:0]             lane_sel;
  logic [LP_NUM_LANES-1:0]         buf_mask_next;
  logic                            buf_busy;
  logic                            buf_drain_last;
  logic                            advance;
  logic                            s_fire;

  genvar gi;
  generate
    for (gi = 0; gi < LP_NUM_LANES; gi++) begin : g_lane
      assign in_lane_mask[gi]  = |s_axis_tkeep[gi*LP_KEEP_W +: LP_KEEP_W];
      assign buf_lane[gi]      = buf_data_reg[gi*C_OUT_WIDTH +: C_OUT_WIDTH];
      assign buf_lane_keep[gi] = buf_keep_reg[gi*LP_KEEP_W +: LP_KEEP_W];
    end
  endgenerate

  // Priority encoder: lowest pending lane wins.
  always_comb begin
    lane_sel = '0;
    for (int i = LP_NUM_LANES - 1; i >= 0; i--) begin
      if (buf_mask_reg[i]) lane_sel = LP_SEL_W'(i);
    end
  end

  // Clearing the lowest set bit leaves the lanes still to be emitted.
  assign buf_mask_next  = buf_mask_reg & (buf_mask_reg - LP_NUM_LANES'(1));
  assign buf_busy       = (|buf_mask_reg) | buf_null_reg;
  assign buf_drain_last = buf_null_reg | ((|buf_mask_reg) && (buf_mask_next == '0));
  assign advance        = !out_valid_reg || m_axis_tready;

  // Accept a new beat only when the buffer is free by the end of this cycle.
  assign s_axis_tready  = run_reg && (!buf_busy || (advance && buf_drain_last));
  assign s_fire         = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_reg       <= 1'b0;
      buf_data_reg  <= '0;
      buf_keep_reg  <= '0;
      buf_last_reg  <= 1'b0;
      buf_mask_reg  <= '0;
      buf_null_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      run_reg <= 1'b1;

      if (advance) begin
        if (|buf_mask_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= buf_lane[lane_sel];
          out_keep_reg  <= buf_lane_keep[lane_sel];
          out_last_reg  <= buf_last_reg && (buf_mask_next == '0);
          buf_mask_reg  <= buf_mask_next;
        end else if (buf_null_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= buf_lane[0];
          out_keep_reg  <= '0;
          out_last_reg  <= 1'b1;
          buf_null_reg  <= 1'b0;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end

      // A beat loads only when the buffer drains this cycle, so it overrides the drain update.
      if (s_fire) begin
        if (|in_lane_mask) begin
          buf_data_reg <= s_axis_tdata;
          buf_keep_reg <= s_axis_tkeep;
          buf_last_reg <= s_axis_tlast;
          buf_mask_reg <= in_lane_mask;
          buf_null_reg <= 1'b0;
        end else if (s_axis_tlast) begin
          buf_data_reg <= s_axis_tdata;
          buf_keep_reg <= '0;
          buf_last_reg <= 1'b1;
          buf_mask_reg <= '0;
          buf_null_reg <= 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tkeep  = out_keep_reg;
  assign m_axis_tlast  = out_last_reg;

endmodule
